uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
UART transmit engine that drains the TX byte FIFO and serializes each byte onto the tx line. The frame is 1 start bit, DATA_BITS data bits sent LSB first, an optional parity bit, then STOP_BITS stop bits. The block is the FIFO's consumer: it issues single-cycle read requests and takes the byte on the registered FIFO read-data output. It sits between the TX FIFO and the pad, as the counterpart of the UART receive path.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 2
DATA_BITS, 8, data bits per frame
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, parity sense when PARITY_EN=1 (0 = even, 1 = odd)
STOP_BITS, 1, stop bits per frame; legal values 1 or 2

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  permits starting new frames; an in-flight frame always completes
fifo_empty  input  1  FIFO empty flag
fifo_rd_data  input  DATA_BITS  FIFO read data; valid the cycle after the FIFO samples fifo_rd_req
fifo_rd_req  output  1  FIFO dequeue request; high for exactly one cycle per byte
tx  output  1  serial line; idle high
busy  output  1  high from REQ through the final stop cycle
byte_done  output  1  one-cycle pulse on the last stop-bit cycle

Behaviour:
- Reset is synchronous on clk and active-high. Reset values: tx=1, busy=0, fifo_rd_req=0, byte_done=0, state=IDLE, counters=0. Reset mid-frame aborts the frame at the next edge and leaves no partial state. The aborted byte is lost.
- States: IDLE, REQ, WAIT, START, DATA, PARITY, STOP.
- IDLE: when enable=1 and fifo_empty=0, go to REQ. Otherwise stay; tx=1.
- REQ (1 cycle): fifo_rd_req=1, busy=1. Go to WAIT. This is the only state in which fifo_rd_req is asserted, so a request is never issued while fifo_empty=1 is sampled in IDLE.
- WAIT (1 cycle): the FIFO presents the byte. At the end of WAIT, latch fifo_rd_data into the shift register, compute parity (XOR of the data bits, inverted if PARITY_ODD), and go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: send DATA_BITS bits LSB first, each held CLKS_PER_BIT cycles. The bit counter is $clog2(DATA_BITS) wide and is compared against DATA_BITS-1.
- PARITY: entered only if PARITY_EN=1; holds the parity bit for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. byte_done=1 on the final cycle.
  - From that final cycle, if enable=1 and fifo_empty=0, go to REQ; otherwise go to IDLE and drop busy.
- Baud counter: $clog2(CLKS_PER_BIT) bits wide. Loads 0 on entry to each bit and wraps at CLKS_PER_BIT-1. A bit transition occurs on the wrap.
- tx is a registered output, driven from state and shift register.
- Back-to-back frames: tx stays high for exactly STOP_BITS*CLKS_PER_BIT + 2 cycles between frames (stop bits, then REQ and WAIT).
- Latency: from fifo_rd_req high to the tx falling edge is 2 cycles.
- enable deassert mid-frame: the frame completes normally and no further REQ is issued.
- fifo_empty changing during WAIT or a frame: ignored; the latched byte is sent.
- Elaboration checks: $error if CLKS_PER_BIT < 2 or STOP_BITS is not 1 or 2.

Decomposition:
- uart_pkg holds:
  - typedef enum tx_state_t {IDLE, REQ, WAIT, START, DATA, PARITY, STOP};
  - localparam DEFAULT_CLKS_PER_BIT = 868;
  - parity helper function, shared with the receive path.
- Sub-module uart_baud_counter: parameter CLKS_PER_BIT; ports clk, reset, clear, tick. tick pulses on the last cycle of each bit period. Reusable by the receiver.

Test Plan:
- Reset with fifo_empty=1 and enable=1 -> tx=1, busy=0, fifo_rd_req never asserted over 50 cycles.
- CLKS_PER_BIT=4, no parity, FIFO holds 0xA5 -> fifo_rd_req for 1 cycle; 2 cycles later tx=0 for 4 cycles; then data 1,0,1,0,0,1,0,1 at 4 cycles each; stop high for 4 cycles; byte_done pulses on the 40th cycle after start; busy falls after that cycle.
- FIFO holds 0x00 then 0xFF, enable=1 -> two frames; tx high for exactly 6 cycles between the last 0 data bit of frame 1 and the start bit of frame 2; exactly two fifo_rd_req pulses.
- PARITY_EN=1: 0x07 with PARITY_ODD=0 -> parity bit 1; 0x07 with PARITY_ODD=1 -> parity bit 0; STOP_BITS=2 -> stop held 8 cycles.
- enable dropped during DATA bit 3 with the FIFO non-empty -> the current frame completes bit-exact; no further fifo_rd_req; busy falls after stop.
- reset asserted during DATA bit 5 -> next cycle tx=1, busy=0. After release and re-enable, the next FIFO byte is sent as a full fresh frame with no residual bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, default baud divisor and
// the parity helper used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int PARITY_MAX_BITS      = 32;

  // Callers zero-extend narrower data; zero bits leave the XOR unchanged.
  function automatic logic parity_bit(input logic [PARITY_MAX_BITS-1:0] data,
                                      input logic                       odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts CLKS_PER_BIT cycles per bit, tick marks the last cycle
// of each period and tick_next the cycle before it.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic tick_next
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_CNT  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: held at zero while cleared, wraps on the last cycle of a bit
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick      = (cnt_q == LAST_CNT);
  assign tick_next = (cnt_q == PRE_CNT) && !clear;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pulls bytes from the TX FIFO and shifts each out as
// start / data (LSB first) / optional parity / stop bits on a registered tx line.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd_req,
  output logic                 tx,
  output logic                 busy,
  output logic                 byte_done
);

  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BCW-1:0] LAST_DATA_BIT = BCW'(DATA_BITS - 1);
  localparam logic           LAST_STOP_BIT = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  tx_state_t            state_q,     state_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic                 parity_q,    parity_d;
  logic [BCW-1:0]       bit_cnt_q,   bit_cnt_d;
  logic                 stop_cnt_q,  stop_cnt_d;
  logic                 tx_q,        tx_d;
  logic                 busy_q,      busy_d;
  logic                 rd_req_q,    rd_req_d;
  logic                 byte_done_q, byte_done_d;

  logic baud_clear_s;
  logic baud_tick_s;
  logic baud_tick_next_s;

  // The baud counter runs only while a bit is on the line, so every START begins at zero
  always_comb begin
    baud_clear_s = 1'b1;
    case (state_q)
      START, DATA, PARITY, STOP: baud_clear_s = 1'b0;
      default:                   baud_clear_s = 1'b1;
    endcase
  end

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (baud_clear_s),
    .tick     (baud_tick_s),
    .tick_next(baud_tick_next_s)
  );

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) state_d = REQ;
        else                       state_d = IDLE;
      end
      REQ: state_d = WAIT;
      WAIT: begin
        shift_d    = fifo_rd_data;
        parity_d   = parity_bit(PARITY_MAX_BITS'(fifo_rd_data), PARITY_ODD != 0);
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        state_d    = START;
      end
      START: begin
        if (baud_tick_s) state_d = DATA;
        else             state_d = START;
      end
      DATA: begin
        if (!baud_tick_s) begin
          state_d = DATA;
        end else if (bit_cnt_q == LAST_DATA_BIT) begin
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
          shift_d   = shift_q >> 1'b1;
          state_d   = DATA;
        end
      end
      PARITY: begin
        if (baud_tick_s) state_d = STOP;
        else             state_d = PARITY;
      end
      STOP: begin
        if (!baud_tick_s) begin
          state_d = STOP;
        end else if (stop_cnt_q != LAST_STOP_BIT) begin
          stop_cnt_d = 1'b1;
          state_d    = STOP;
        end else if (enable && !fifo_empty) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so their flops line up with state_q
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
    busy_d      = (state_d != IDLE);
    rd_req_d    = (state_d == REQ);
    byte_done_d = (state_q == STOP) && (stop_cnt_q == LAST_STOP_BIT) && baud_tick_next_s;
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      rd_req_q    <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      rd_req_q    <= rd_req_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign fifo_rd_req = rd_req_q;
  assign byte_done   = byte_done_q;

endmodule
